// File: rtl/rom_arb_pkg.sv
// Shared types and constants for the boot ROM arbiter.
package rom_arb_pkg;

    localparam int unsigned ADDR_W_DEF = 4;
    localparam int unsigned WAIT_DEF   = 2;
    localparam int unsigned WCNT_W     = 4;
    localparam int unsigned DATA_W     = 8;

    localparam logic PORT_CPU = 1'b0;
    localparam logic PORT_DBG = 1'b1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

endpackage

// File: rtl/rom_arb_pick.sv
// Combinational winner select between the CPU and debug ports.
// ROM_ARB_ROUND_ROBIN_EN selects alternating priority on ties; default is CPU-first.
module rom_arb_pick
    import rom_arb_pkg::*;
(
    input  logic cpu_req,
    input  logic dbg_req,
    input  logic last_gnt,
    output logic any_c,
    output logic win_c
);

`ifdef ROM_ARB_ROUND_ROBIN_EN
    always_comb begin
        any_c = cpu_req | dbg_req;
        win_c = PORT_CPU;
        if (cpu_req && dbg_req) begin
            win_c = ~last_gnt;
        end else if (dbg_req) begin
            win_c = PORT_DBG;
        end
    end
`else
    logic unused_last_gnt;
    assign unused_last_gnt = last_gnt;

    always_comb begin
        any_c = cpu_req | dbg_req;
        win_c = PORT_CPU;
        if (!cpu_req && dbg_req) begin
            win_c = PORT_DBG;
        end
    end
`endif

endmodule

// File: rtl/rom_arbiter.sv
// Two-port arbiter sequencing accesses to the async boot ROM with fixed access time.
// Tie policy is set in rom_arb_pick by ROM_ARB_ROUND_ROBIN_EN.
module rom_arbiter
    import rom_arb_pkg::*;
#(
    parameter int unsigned ADDR_W      = ADDR_W_DEF,
    parameter int unsigned WAIT_CYCLES = WAIT_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic [ADDR_W-1:0] cpu_addr,
    output logic              cpu_ack,
    input  logic              dbg_req,
    input  logic [ADDR_W-1:0] dbg_addr,
    output logic              dbg_ack,
    output logic [DATA_W-1:0] rdata,
    output logic              rom_sel,
    output logic [ADDR_W-1:0] rom_a,
    input  logic [DATA_W-1:0] rom_dout,
    output logic              busy
);

    state_t              state, state_d;
    logic [WCNT_W-1:0]   wcnt, wcnt_d;
    logic                gnt_id, gnt_id_d;
    logic                last_gnt, last_gnt_d;
    logic                rom_sel_d, cpu_ack_d, dbg_ack_d, busy_d;
    logic [ADDR_W-1:0]   rom_a_d;
    logic [DATA_W-1:0]   rdata_d;
    logic                any_c, win_c;

    rom_arb_pick u_pick (
        .cpu_req  (cpu_req),
        .dbg_req  (dbg_req),
        .last_gnt (last_gnt),
        .any_c    (any_c),
        .win_c    (win_c)
    );

    // rom_a doubles as the latched request address; it only changes on a grant.
    always_comb begin
        state_d    = state;
        wcnt_d     = wcnt;
        gnt_id_d   = gnt_id;
        last_gnt_d = last_gnt;
        rom_sel_d  = rom_sel;
        rom_a_d    = rom_a;
        rdata_d    = rdata;
        cpu_ack_d  = 1'b0;
        dbg_ack_d  = 1'b0;
        case (state)
            IDLE: begin
                if (any_c) begin
                    gnt_id_d  = win_c;
                    rom_a_d   = (win_c == PORT_DBG) ? dbg_addr : cpu_addr;
                    wcnt_d    = WCNT_W'(WAIT_CYCLES);
                    rom_sel_d = 1'b1;
                    state_d   = ACCESS;
                end
            end
            ACCESS: begin
                if (wcnt != '0) begin
                    wcnt_d = wcnt - WCNT_W'(1);
                end else begin
                    rdata_d   = rom_dout;
                    rom_sel_d = 1'b0;
                    if (gnt_id == PORT_DBG) begin
                        dbg_ack_d = 1'b1;
                    end else begin
                        cpu_ack_d = 1'b1;
                    end
                    state_d = DONE;
                end
            end
            DONE: begin
                last_gnt_d = gnt_id;
                state_d    = IDLE;
            end
            default: begin
                rom_sel_d = 1'b0;
                state_d   = IDLE;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            wcnt     <= '0;
            gnt_id   <= PORT_CPU;
            last_gnt <= PORT_DBG;
            rom_sel  <= 1'b0;
            rom_a    <= '0;
            rdata    <= '0;
            cpu_ack  <= 1'b0;
            dbg_ack  <= 1'b0;
            busy     <= 1'b0;
        end else begin
            state    <= state_d;
            wcnt     <= wcnt_d;
            gnt_id   <= gnt_id_d;
            last_gnt <= last_gnt_d;
            rom_sel  <= rom_sel_d;
            rom_a    <= rom_a_d;
            rdata    <= rdata_d;
            cpu_ack  <= cpu_ack_d;
            dbg_ack  <= dbg_ack_d;
            busy     <= busy_d;
        end
    end

endmodule

// File: tb/tb_rom_arbiter.sv
// Self-checking bench for rom_arbiter: directed test-plan cases then randomized traffic,
// compared cycle by cycle against a transaction-timeline reference model.
module tb_rom_arbiter;

    localparam int unsigned AW = 4;
    localparam int unsigned W  = 2;
`ifdef ROM_ARB_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic          cpu_req, dbg_req, cpu_ack, dbg_ack, rom_sel, busy;
    logic [AW-1:0] cpu_addr, dbg_addr, rom_a;
    logic [7:0]    rdata, rom_dout;
    logic [7:0]    rom_mem [16];

    rom_arbiter #(.ADDR_W(AW), .WAIT_CYCLES(W)) dut (
        .clk      (clk),
        .reset    (reset),
        .cpu_req  (cpu_req),
        .cpu_addr (cpu_addr),
        .cpu_ack  (cpu_ack),
        .dbg_req  (dbg_req),
        .dbg_addr (dbg_addr),
        .dbg_ack  (dbg_ack),
        .rdata    (rdata),
        .rom_sel  (rom_sel),
        .rom_a    (rom_a),
        .rom_dout (rom_dout),
        .busy     (busy)
    );

    assign rom_dout = rom_mem[rom_a];
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // Reference model: one access is a timeline anchored at its grant edge.
    int         cyc;
    int         m_start;
    bit         m_active;
    bit         m_id;
    bit         m_last;
    logic [3:0] m_addr;
    logic [7:0] m_rdata;
    bit         saw_cpu, saw_dbg;
    logic [7:0] saw_data;

    task automatic step();
        int k;
        logic e_sel, e_busy, e_cack, e_dack;
        bit w;
        @(negedge clk);
        e_sel = 1'b0; e_busy = 1'b0; e_cack = 1'b0; e_dack = 1'b0;
        k = cyc - m_start;
        if (m_active) begin
            if (k >= 1 && k <= int'(W) + 1) begin
                e_sel  = 1'b1;
                e_busy = 1'b1;
            end
            if (k == int'(W) + 2) begin
                e_busy  = 1'b1;
                m_rdata = rom_mem[m_addr];
                m_last  = m_id;
                if (m_id) e_dack = 1'b1;
                else      e_cack = 1'b1;
            end
        end
        check("rom_sel", 32'(rom_sel), 32'(e_sel));
        check("busy", 32'(busy), 32'(e_busy));
        check("cpu_ack", 32'(cpu_ack), 32'(e_cack));
        check("dbg_ack", 32'(dbg_ack), 32'(e_dack));
        check("rdata", 32'(rdata), 32'(m_rdata));
        if (e_sel) check("rom_a", 32'(rom_a), 32'(m_addr));
        saw_cpu  = cpu_ack;
        saw_dbg  = dbg_ack;
        saw_data = rdata;
        @(posedge clk);
        if (reset) begin
            m_active = 1'b0;
            m_rdata  = 8'h00;
            m_last   = 1'b1;
        end else if ((!m_active || (cyc - m_start) >= int'(W) + 3) && (cpu_req || dbg_req)) begin
            if (cpu_req && dbg_req) w = RR ? !m_last : 1'b0;
            else                    w = !cpu_req;
            m_active = 1'b1;
            m_start  = cyc;
            m_id     = w;
            m_addr   = w ? dbg_addr : cpu_addr;
        end
        cyc++;
        #1;
    endtask

    task automatic wait_ack(output bit port, output int n, output logic [7:0] d);
        bit found;
        found = 1'b0;
        port  = 1'b0;
        n     = 0;
        d     = 8'h00;
        for (int i = 0; i < 40 && !found; i++) begin
            step();
            n++;
            if (saw_cpu || saw_dbg) begin
                found = 1'b1;
                port  = saw_dbg;
                d     = saw_data;
            end
        end
        if (!found) check("ack_timeout", 32'd0, 32'd1);
    endtask

    bit         port;
    int         n;
    logic [7:0] d;
    bit         rq [2];
    logic [3:0] ad [2];

    initial begin
        rom_mem = '{8'h4F, 8'h4C, 8'h5C, 8'h48, 8'hA3, 8'h17, 8'hC8, 8'h3E,
                    8'h91, 8'h06, 8'h7D, 8'hE2, 8'h5A, 8'hB4, 8'hFF, 8'hF0};
        reset = 1'b1; cpu_req = 1'b0; dbg_req = 1'b0; cpu_addr = '0; dbg_addr = '0;
        cyc = 0; m_start = 0; m_active = 1'b0; m_id = 1'b0; m_last = 1'b1;
        m_addr = '0; m_rdata = 8'h00;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        // CPU alone, address 0
        cpu_req = 1'b1; cpu_addr = 4'h0;
        wait_ack(port, n, d);
        check("a_port", 32'(port), 32'd0);
        check("a_lat", 32'(n), 32'(W + 3));
        check("a_data", 32'(d), 32'h4F);
        cpu_req = 1'b0;

        // debug alone, address E
        dbg_req = 1'b1; dbg_addr = 4'hE;
        wait_ack(port, n, d);
        check("b_port", 32'(port), 32'd1);
        check("b_lat", 32'(n), 32'(W + 3));
        check("b_data", 32'(d), 32'hFF);
        dbg_req = 1'b0;

        // simultaneous requests: CPU first, then debug
        cpu_req = 1'b1; cpu_addr = 4'h1; dbg_req = 1'b1; dbg_addr = 4'hF;
        wait_ack(port, n, d);
        check("c_first", 32'(port), 32'd0);
        check("c_first_data", 32'(d), 32'h4C);
        cpu_req = 1'b0;
        wait_ack(port, n, d);
        check("c_second", 32'(port), 32'd1);
        check("c_second_data", 32'(d), 32'hF0);
        check("c_second_lat", 32'(n), 32'(W + 3));

        // both held over four accesses
        cpu_req = 1'b1;
        for (int i = 0; i < 4; i++) begin
            wait_ack(port, n, d);
            check("c_order", 32'(port), RR ? 32'(i % 2) : 32'd0);
            check("c_order_gap", 32'(n), 32'(W + 3));
        end
        cpu_req = 1'b0; dbg_req = 1'b0;
        step();

        // CPU back-to-back on 1, 2, 3
        cpu_req = 1'b1; cpu_addr = 4'h1;
        wait_ack(port, n, d);
        check("d_data1", 32'(d), 32'h4C);
        cpu_addr = 4'h2;
        wait_ack(port, n, d);
        check("d_gap2", 32'(n), 32'(W + 3));
        check("d_data2", 32'(d), 32'h5C);
        cpu_addr = 4'h3;
        wait_ack(port, n, d);
        check("d_gap3", 32'(n), 32'(W + 3));
        check("d_data3", 32'(d), 32'h48);
        cpu_req = 1'b0;
        step();

        // reset during the second ACCESS cycle
        cpu_req = 1'b1; cpu_addr = 4'h5;
        step();
        step();
        reset = 1'b1;
        step();
        reset = 1'b0; cpu_req = 1'b0;
        check("e_sel", 32'(rom_sel), 32'd0);
        check("e_busy", 32'(busy), 32'd0);
        check("e_rdata", 32'(rdata), 32'h00);
        check("e_ack", 32'({cpu_ack, dbg_ack}), 32'd0);
        repeat (W + 3) step();
        cpu_req = 1'b1; cpu_addr = 4'h3;
        wait_ack(port, n, d);
        check("e_after_port", 32'(port), 32'd0);
        check("e_after_data", 32'(d), 32'h48);
        cpu_req = 1'b0;

        // randomized traffic
        rq[0] = 1'b0; rq[1] = 1'b0; ad[0] = '0; ad[1] = '0;
        for (int it = 0; it < 800; it++) begin
            step();
            for (int p = 0; p < 2; p++) begin
                bit acked, inflight;
                acked    = (p == 1) ? saw_dbg : saw_cpu;
                inflight = !reset && m_active && (m_id == p[0]) &&
                           ((cyc - 1 - m_start) < int'(W) + 2);
                if (acked) begin
                    rq[p] = ($urandom % 2) == 0;
                    ad[p] = 4'($urandom);
                end else if (inflight) begin
                    if ($urandom % 8 == 0) ad[p] = 4'($urandom);
                    if ($urandom % 8 == 0) rq[p] = 1'b0;
                end else if (!rq[p]) begin
                    if ($urandom % 3 == 0) begin
                        rq[p] = 1'b1;
                        ad[p] = 4'($urandom);
                    end
                end
            end
            reset    = ($urandom % 200) == 0;
            cpu_req  = rq[0]; cpu_addr = ad[0];
            dbg_req  = rq[1]; dbg_addr = ad[1];
        end
        reset = 1'b0; cpu_req = 1'b0; dbg_req = 1'b0;
        repeat (W + 6) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
